// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared constants, FSM state type and nibble-to-ASCII helper for the digest path
package hash_pkg;

   localparam int N_H = 8;
   localparam int H_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Lowercase hex digit: 0-9 -> 8'h30-8'h39, a-f -> 8'h61-8'h66
   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      logic [7:0] wide;
      wide = {4'h0, nib};
      return (nib < 4'd10) ? (8'h30 + wide) : (8'h57 + wide);
   endfunction

endpackage

// File: rtl/hex_nibble_enc.sv
// rtl/hex_nibble_enc.sv - combinational 4-bit nibble to lowercase ASCII hex character
module hex_nibble_enc
   import hash_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   assign ascii = hex_char(nibble);

endmodule

// File: rtl/digest_serializer.sv
// rtl/digest_serializer.sv - snapshots the hash words on start and streams them out one beat per handshake (DIGEST_HEX_ASCII_EN selects ASCII hex output)
module digest_serializer
   import hash_pkg::*;
#(
   parameter  int N_WORDS = N_H,
   parameter  int WORD_W  = H_W,
   localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
`ifdef DIGEST_HEX_ASCII_EN
   localparam int OUT_W   = 8
`else
   localparam int OUT_W   = WORD_W
`endif
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [WORD_W-1:0] H_in [0:N_WORDS-1],
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic [IDX_W-1:0]  out_idx
);

   state_t            state_q;
   state_t            state_d;
   logic [WORD_W-1:0] snap_q [0:N_WORDS-1];
   logic [IDX_W-1:0]  word_idx_q;
   logic              done_q;
   logic              last_char;
   logic              last_beat;
   logic              accept;
   logic [WORD_W-1:0] cur_word;

   assign cur_word  = snap_q[word_idx_q];
   assign accept    = (state_q == SEND) && out_ready;
   assign last_beat = (word_idx_q == IDX_W'(N_WORDS - 1)) && last_char;

`ifdef DIGEST_HEX_ASCII_EN
   localparam int N_CHARS = WORD_W / 4;
   localparam int CH_W    = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;

   logic [CH_W-1:0] char_idx_q;
   logic [3:0]      nibble;
   logic [7:0]      ascii;

   assign last_char = (char_idx_q == CH_W'(N_CHARS - 1));

   // Characters go out most-significant nibble first
   always_comb begin
      nibble = cur_word[(N_CHARS - 1 - int'(char_idx_q)) * 4 +: 4];
   end

   hex_nibble_enc u_hex_nibble_enc (
      .nibble (nibble),
      .ascii  (ascii)
   );

   // Character position within the current word; wraps at each word boundary
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         char_idx_q <= '0;
      end else if (state_q == IDLE && start) begin
         char_idx_q <= '0;
      end else if (accept) begin
         char_idx_q <= last_char ? '0 : char_idx_q + 1'b1;
      end
   end

   assign out_data = out_valid ? ascii : '0;
`else
   assign last_char = 1'b1;
   assign out_data  = out_valid ? cur_word : '0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and stream-side status; start is only looked at in IDLE
   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = SEND;
         end
         SEND: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready && last_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Snapshot capture, word counter and the end-of-digest pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_WORDS; i++) snap_q[i] <= '0;
         word_idx_q <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= accept && last_beat;
         if (state_q == IDLE && start) begin
            snap_q     <= H_in;
            word_idx_q <= '0;
         end else if (accept && last_char) begin
            word_idx_q <= last_beat ? '0 : word_idx_q + 1'b1;
         end
      end
   end

   assign done     = done_q;
   assign out_idx  = word_idx_q;
   assign out_last = out_valid && last_beat;

endmodule
